phy_rx_complex_state: RTL
=========================

Name: phy_rx_complex_state

Overview:
- Receive-side PHY framer and inverse of the GT transmit framer.
- Takes the 32-bit GT RX stream (data + charisk) and locks byte alignment on K28.5 commas (50BC50BC).
- Strips SOF (FB) and EOF (FD) control characters and reassembles payload into an AXI-Stream master bus: 32-bit words, MSB-first byte order, MSB-justified keep on the last beat.
- Sits between the GT RX channel and the user RX logic; no backpressure toward the GT.

Parameters:
P_LOCK_TIMEOUT, 2048, idle cycles without a valid comma before lock is dropped
P_MAX_BYTES, 4096, maximum payload bytes per frame; exceeding it is a framing error

Ports:
i_clk  in  1  clock (GT RX user clock)
i_rst  in  1  synchronous active-high reset
i_gt_rx_done  in  1  GT RX reset/init complete
i_gt_rx_data  in  32  RX data; lane 0 = [7:0] = first byte in time
i_gt_rx_charisk  in  4  per-lane K flag
o_axi_m_valid  out  1  payload beat valid; no ready, sink must always accept
o_axi_m_data  out  32  payload word; first byte at [31:24]
o_axi_m_keep  out  4  byte enables, MSB-justified (1111/1110/1100/1000)
o_axi_m_last  out  1  last beat of frame
o_rx_lock  out  1  alignment locked
o_rx_err  out  1  one-cycle pulse on framing error

Behaviour:
- Reset: all outputs 0; state INIT; offset 0; all counters 0.
- Align stage (always registered, 1 cycle):
  - Keep r_prev = previous raw word and charisk.
  - Offset 0: aligned = current word.
  - Offset 1: aligned = {cur[23:0], prev[31:24]}, k = {curk[2:0], prevk[3]}.
  - Comma detect on raw input: data 50BC50BC with k 0101 -> offset 0; data BC50BC50 with k 1010 -> offset 1.
- FSM on the aligned word:
  - INIT: i_gt_rx_done=1 -> UNLOCK.
  - UNLOCK: raw comma -> latch offset, o_rx_lock=1 -> IDLE.
  - IDLE:
    - Comma matching the current offset -> clear timeout counter.
    - Comma at the other offset -> re-latch offset and pulse o_rx_err.
    - k==0001 and byte0==FB -> latch bytes 1..3 into a 3-byte carry, clear byte count -> DATA.
    - Other words (LFSR filler, k=0) are ignored.
    - Timeout counter reaching P_LOCK_TIMEOUT -> o_rx_lock=0 -> UNLOCK.
  - DATA:
    - k==0: emit {carry, byte0}, keep 1111; carry <= bytes 1..3; byte count += 4.
    - Exactly one k bit at lane n with that byte == FD -> EOF. Total remaining = 3+n bytes:
      - n=0: one beat, {carry,00}, keep 1110, last.
      - n=1: one beat, {carry,b0}, keep 1111, last.
      - n=2: beat {carry,b0} keep 1111, then next cycle {b1,000000} keep 1000, last.
      - n=3: beat {carry,b0} keep 1111, then next cycle {b1,b2,0000} keep 1100, last.
      - Then -> IDLE; the second-beat cycle ignores the aligned input (it is filler or comma by protocol).
    - Any other K pattern, byte count > P_MAX_BYTES, or i_gt_rx_done falling:
      - Flush carry as {carry,00}, keep 1110, last=1.
      - o_rx_err=1 on the same cycle.
      - -> IDLE, or -> INIT if done fell.
- i_gt_rx_done=0 in any state -> INIT; o_rx_lock=0 on the next edge.
- o_axi_m_valid is never asserted outside DATA or the EOF second-beat cycle. Every frame that enters DATA ends with exactly one beat with last=1.
- Latency: a data word presented at the GT input at cycle t appears on o_axi_m_* at t+2, for both offsets.
- Byte count is 16 bits and saturates; it never wraps.

Test Plan:
- Reset, then i_gt_rx_done=1, input 50BC50BC/0101 -> o_rx_lock=1 at the second edge; no valid output.
- Offset 0, frame FB/0001 {11,22,33}, 44556677/0, then FD at lane 1 (b0=88) -> beats 11223344/1111, then 55667788/1111 last.
- Offset 1 comma BC50BC50/1010, then the same frame shifted one byte -> identical output beats, same relative latency.
- EOF with FD at lanes 0, 2, 3 after a 7-byte frame prefix -> keep 1110 single beat; 1111 + 1000 last; 1111 + 1100 last, respectively, second beat exactly one cycle later.
- Mid-frame input 50BC50BC/0101 -> flush beat {carry,00}, keep 1110, last, with an o_rx_err pulse; FSM back in IDLE and accepts the next FB frame.
- No commas for 2048 idle cycles -> o_rx_lock falls; frame of 4100 bytes -> error flush after byte 4096 is exceeded; i_gt_rx_done dropped mid-frame -> flush+err, then INIT.

Source files
------------

// File: rtl/phy_rx_complex_state.sv
// -----------------------------------------------------------------------------
// phy_rx_complex_state
//   Receive-side PHY framer. Locks byte alignment on K28.5 commas arriving on
//   the 32-bit GT RX stream, strips the SOF (K27.7, FB) and EOF (K29.7, FD)
//   control characters and repacks the payload into a 32-bit AXI-Stream
//   master (first byte at [31:24], MSB-justified keep on the last beat).
//   There is no backpressure: the sink must accept every valid beat.
//
// Ports
//   i_clk            GT RX user clock
//   i_rst            synchronous active-high reset
//   i_gt_rx_done     GT RX init complete; low forces the framer back to INIT
//   i_gt_rx_data     raw RX word, lane 0 = [7:0] = first byte in time
//   i_gt_rx_charisk  per-lane K flag
//   o_axi_m_valid    payload beat valid
//   o_axi_m_data     payload word, first byte at [31:24]
//   o_axi_m_keep     byte enables, MSB-justified
//   o_axi_m_last     last beat of a frame
//   o_rx_lock        alignment locked
//   o_rx_err         one-cycle pulse on a framing error
// -----------------------------------------------------------------------------
module phy_rx_complex_state #(
  parameter int P_LOCK_TIMEOUT = 2048,
  parameter int P_MAX_BYTES    = 4096
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_gt_rx_done,
  input  logic [31:0] i_gt_rx_data,
  input  logic [3:0]  i_gt_rx_charisk,
  output logic        o_axi_m_valid,
  output logic [31:0] o_axi_m_data,
  output logic [3:0]  o_axi_m_keep,
  output logic        o_axi_m_last,
  output logic        o_rx_lock,
  output logic        o_rx_err
);

  localparam int              LP_TO_W      = $clog2(P_LOCK_TIMEOUT) + 1;
  localparam logic [LP_TO_W-1:0] LP_TO_LAST = LP_TO_W'(P_LOCK_TIMEOUT - 1);
  localparam logic [LP_TO_W-1:0] LP_TO_ONE  = LP_TO_W'(1);
  localparam logic [LP_TO_W-1:0] LP_TO_ZERO = LP_TO_W'(0);
  localparam logic [15:0]     LP_MAX_BYTES = 16'(P_MAX_BYTES);
  localparam logic [7:0]      LP_K_SOF     = 8'hFB;
  localparam logic [7:0]      LP_K_EOF     = 8'hFD;
  localparam logic [31:0]     LP_COMMA_0   = 32'h50BC50BC;
  localparam logic [31:0]     LP_COMMA_1   = 32'hBC50BC50;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_UNLOCK = 3'd1,
    ST_IDLE   = 3'd2,
    ST_DATA   = 3'd3,
    ST_EOF2   = 3'd4
  } state_t;

  state_t               state_r;
  logic                 offset_r;
  logic [31:0]          prev_data_r;
  logic [3:0]           prev_k_r;
  logic [31:0]          aln_data_r;
  logic [3:0]           aln_k_r;
  logic [23:0]          carry_r;
  logic [15:0]          byte_cnt_r;
  logic [LP_TO_W-1:0]   to_cnt_r;
  logic [31:0]          tail_data_r;
  logic [3:0]           tail_keep_r;
  logic                 valid_r;
  logic [31:0]          data_r;
  logic [3:0]           keep_r;
  logic                 last_r;
  logic                 lock_r;
  logic                 err_r;

  logic [31:0]          aln_data_s;
  logic [3:0]           aln_k_s;
  logic                 comma0_s;
  logic                 comma1_s;
  logic                 comma_match_s;
  logic                 comma_other_s;
  logic [7:0]           b0_s, b1_s, b2_s, b3_s;
  logic                 sof_s;
  logic                 eof_hit_s;
  logic [1:0]           eof_lane_s;
  logic [15:0]          cnt_inc_s;
  logic                 frame_err_s;

  // Byte-rotate the raw word by the locked offset; offset 1 borrows the
  // last lane of the previous word as the first byte in time.
  always_comb begin
    aln_data_s = i_gt_rx_data;
    aln_k_s    = i_gt_rx_charisk;
    if (offset_r) begin
      aln_data_s = {i_gt_rx_data[23:0], prev_data_r[31:24]};
      aln_k_s    = {i_gt_rx_charisk[2:0], prev_k_r[3]};
    end else begin
      aln_data_s = i_gt_rx_data;
      aln_k_s    = i_gt_rx_charisk;
    end
  end

  // Comma detection runs on the raw input so lock can be acquired before the
  // offset is known.
  always_comb begin
    comma0_s      = (i_gt_rx_data == LP_COMMA_0) && (i_gt_rx_charisk == 4'b0101);
    comma1_s      = (i_gt_rx_data == LP_COMMA_1) && (i_gt_rx_charisk == 4'b1010);
    comma_match_s = 1'b0;
    comma_other_s = 1'b0;
    if (offset_r) begin
      comma_match_s = comma1_s;
      comma_other_s = comma0_s;
    end else begin
      comma_match_s = comma0_s;
      comma_other_s = comma1_s;
    end
  end

  // Decode control characters in the aligned word and the saturating count.
  always_comb begin
    b0_s       = aln_data_r[7:0];
    b1_s       = aln_data_r[15:8];
    b2_s       = aln_data_r[23:16];
    b3_s       = aln_data_r[31:24];
    sof_s      = (aln_k_r == 4'b0001) && (b0_s == LP_K_SOF);
    eof_hit_s  = 1'b0;
    eof_lane_s = 2'd0;
    case (aln_k_r)
      4'b0001: begin eof_hit_s = (b0_s == LP_K_EOF); eof_lane_s = 2'd0; end
      4'b0010: begin eof_hit_s = (b1_s == LP_K_EOF); eof_lane_s = 2'd1; end
      4'b0100: begin eof_hit_s = (b2_s == LP_K_EOF); eof_lane_s = 2'd2; end
      4'b1000: begin eof_hit_s = (b3_s == LP_K_EOF); eof_lane_s = 2'd3; end
      default: begin eof_hit_s = 1'b0;               eof_lane_s = 2'd0; end
    endcase
    if (byte_cnt_r > 16'hFFFB) begin
      cnt_inc_s = 16'hFFFF;
    end else begin
      cnt_inc_s = byte_cnt_r + 16'd4;
    end
    // The count check uses the bytes already accepted before this word.
    frame_err_s = (!i_gt_rx_done) || (byte_cnt_r > LP_MAX_BYTES) ||
                  !((aln_k_r == 4'b0000) || eof_hit_s);
  end

  // Alignment pipeline register: previous raw word and the aligned word.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev_data_r <= 32'd0;
      prev_k_r    <= 4'd0;
      aln_data_r  <= 32'd0;
      aln_k_r     <= 4'd0;
    end else begin
      prev_data_r <= i_gt_rx_data;
      prev_k_r    <= i_gt_rx_charisk;
      aln_data_r  <= aln_data_s;
      aln_k_r     <= aln_k_s;
    end
  end

  // Framing FSM with registered AXI-Stream and status outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= ST_INIT;
      offset_r    <= 1'b0;
      carry_r     <= 24'd0;
      byte_cnt_r  <= 16'd0;
      to_cnt_r    <= LP_TO_ZERO;
      tail_data_r <= 32'd0;
      tail_keep_r <= 4'd0;
      valid_r     <= 1'b0;
      data_r      <= 32'd0;
      keep_r      <= 4'd0;
      last_r      <= 1'b0;
      lock_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      data_r  <= 32'd0;
      keep_r  <= 4'd0;
      last_r  <= 1'b0;
      err_r   <= 1'b0;
      case (state_r)
        ST_INIT: begin
          lock_r <= 1'b0;
          if (i_gt_rx_done) state_r <= ST_UNLOCK;
        end
        ST_UNLOCK: begin
          if (!i_gt_rx_done) begin
            state_r <= ST_INIT;
            lock_r  <= 1'b0;
          end else if (comma0_s || comma1_s) begin
            offset_r <= comma1_s;
            lock_r   <= 1'b1;
            to_cnt_r <= LP_TO_ZERO;
            state_r  <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (!i_gt_rx_done) begin
            state_r <= ST_INIT;
            lock_r  <= 1'b0;
          end else if (sof_s) begin
            carry_r    <= {b1_s, b2_s, b3_s};
            byte_cnt_r <= 16'd0;
            to_cnt_r   <= LP_TO_ZERO;
            state_r    <= ST_DATA;
          end else if (comma_match_s) begin
            to_cnt_r <= LP_TO_ZERO;
          end else if (comma_other_s) begin
            // Alignment slipped while idle: follow the new comma position.
            offset_r <= ~offset_r;
            err_r    <= 1'b1;
            to_cnt_r <= LP_TO_ZERO;
          end else if (to_cnt_r == LP_TO_LAST) begin
            lock_r  <= 1'b0;
            state_r <= ST_UNLOCK;
          end else begin
            to_cnt_r <= to_cnt_r + LP_TO_ONE;
          end
        end
        ST_DATA: begin
          if (frame_err_s) begin
            // Close the frame with whatever is carried so the sink always
            // sees exactly one last beat per frame.
            valid_r <= 1'b1;
            data_r  <= {carry_r, 8'h00};
            keep_r  <= 4'b1110;
            last_r  <= 1'b1;
            err_r   <= 1'b1;
            if (i_gt_rx_done) begin
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_INIT;
              lock_r  <= 1'b0;
            end
          end else if (aln_k_r == 4'b0000) begin
            valid_r    <= 1'b1;
            data_r     <= {carry_r, b0_s};
            keep_r     <= 4'b1111;
            carry_r    <= {b1_s, b2_s, b3_s};
            byte_cnt_r <= cnt_inc_s;
          end else begin
            // EOF at lane n leaves 3+n payload bytes: carry plus lanes below n.
            valid_r <= 1'b1;
            state_r <= ST_IDLE;
            case (eof_lane_s)
              2'd0: begin
                data_r <= {carry_r, 8'h00};
                keep_r <= 4'b1110;
                last_r <= 1'b1;
              end
              2'd1: begin
                data_r <= {carry_r, b0_s};
                keep_r <= 4'b1111;
                last_r <= 1'b1;
              end
              2'd2: begin
                data_r      <= {carry_r, b0_s};
                keep_r      <= 4'b1111;
                tail_data_r <= {b1_s, 24'h000000};
                tail_keep_r <= 4'b1000;
                state_r     <= ST_EOF2;
              end
              default: begin
                data_r      <= {carry_r, b0_s};
                keep_r      <= 4'b1111;
                tail_data_r <= {b1_s, b2_s, 16'h0000};
                tail_keep_r <= 4'b1100;
                state_r     <= ST_EOF2;
              end
            endcase
          end
        end
        ST_EOF2: begin
          // Aligned input here is inter-frame filler; only the tail is sent.
          valid_r <= 1'b1;
          data_r  <= tail_data_r;
          keep_r  <= tail_keep_r;
          last_r  <= 1'b1;
          if (i_gt_rx_done) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_INIT;
            lock_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_INIT;
          lock_r  <= 1'b0;
        end
      endcase
    end
  end

  assign o_axi_m_valid = valid_r;
  assign o_axi_m_data  = data_r;
  assign o_axi_m_keep  = keep_r;
  assign o_axi_m_last  = last_r;
  assign o_rx_lock     = lock_r;
  assign o_rx_err      = err_r;

endmodule
